// File: rtl/sb_pkg.sv
// sb_pkg: shared constants, state/kind enums and the CRC-16 byte step for
// the sideband transaction transmitter.
//   DLE/STX_CMD/STX_RSP/ETX/LSE/CLSE : framing byte values
//   SBTX_IDLE                        : line value between symbols/frames
//   tx_state_e                       : transmitter symbol state
//   tx_kind_e                        : transaction type latched at accept
//   crc16_byte()                     : CRC-16 (0x8005, MSB-first) over one byte
package sb_pkg;

  localparam logic [7:0]  DLE       = 8'hFE;
  localparam logic [7:0]  STX_CMD   = 8'h05;
  localparam logic [7:0]  STX_RSP   = 8'h04;
  localparam logic [7:0]  ETX       = 8'h40;
  localparam logic [7:0]  LSE       = 8'hA0;
  localparam logic [7:0]  CLSE      = 8'h5F;
  localparam logic [9:0]  SBTX_IDLE = 10'h3FF;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'h8005;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DLE_H,
    ST_STX,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_STUFF,
    ST_DLE_T,
    ST_ETX,
    ST_LSE,
    ST_CLSE
  } tx_state_e;

  typedef enum logic [1:0] {
    KIND_CMD,
    KIND_RSP,
    KIND_LT
  } tx_kind_e;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  din);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ din[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_crc16.sv
// sb_crc16: running CRC-16 register, one byte per enabled cycle.
//   sb_clk : clock
//   rst    : synchronous active-high reset (crc = FFFF)
//   init   : reload FFFF (wins over en)
//   en     : fold din into the running CRC
//   din    : byte to fold in
//   crc    : current CRC value
module sb_crc16
  import sb_pkg::*;
(
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge sb_clk) begin
    if (rst)       crc_q <= CRC_INIT;
    else if (init) crc_q <= CRC_INIT;
    else if (en)   crc_q <= crc16_byte(crc_q, din);
  end

  assign crc = crc_q;

endmodule

// File: rtl/sb_trans_tx.sv
// sb_trans_tx: sideband transaction transmitter. Frames AT command, AT
// response and LT-fall transactions onto the 10-bit sbtx symbol stream with
// DLE/STX/ETX framing, DLE stuffing and CRC-16; one symbol per SYM_CYCLES.
//   sb_clk, rst (sync, active high), tdisconnect (abort to IDLE)
//   at_cmd_req / at_rsp_req / lt_fall_req : level requests (lt > rsp > cmd)
//   req_write, req_address, req_len, req_payload : captured on accept
//   tx_busy, tx_done (1-cycle), sbtx {1,byte,0}, sbtx_strobe (new symbol)
//   tx_frame_cnt : completed-frame counter, present only with
//                  SB_TX_FRAME_CNT_EN defined
//
// state     | meaning
// IDLE      | line idle (3FF), waiting for a request
// DLE_H     | leading DLE
// STX       | STX_CMD / STX_RSP
// ADDR      | address byte
// LEN       | {rw, len}
// DATA      | payload byte idx_q
// CRC_LO    | crc[7:0]
// CRC_HI    | crc[15:8]
// STUFF     | duplicate FE after a stuffable FE byte, then resume at ret_q
// DLE_T     | trailing DLE
// ETX       | ETX, last symbol of an AT frame
// LSE       | LT fall LSE
// CLSE      | LT fall CLSE, last symbol of an LT frame
module sb_trans_tx
  import sb_pkg::*;
#(
  parameter int SYM_CYCLES = 10,
  parameter int MAX_DATA   = 3
) (
  input  logic                  sb_clk,
  input  logic                  rst,
  input  logic                  tdisconnect,
  input  logic                  at_cmd_req,
  input  logic                  at_rsp_req,
  input  logic                  lt_fall_req,
  input  logic                  req_write,
  input  logic [7:0]            req_address,
  input  logic [1:0]            req_len,
  input  logic [8*MAX_DATA-1:0] req_payload,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [9:0]            sbtx,
  output logic                  sbtx_strobe
`ifdef SB_TX_FRAME_CNT_EN
  ,
  output logic [15:0]           tx_frame_cnt
`endif
);

  localparam int          CW      = (SYM_CYCLES > 2) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SYM_CYCLES - 1);
  localparam logic [1:0]  MAX_LEN = (MAX_DATA >= 3) ? 2'd3 : 2'(MAX_DATA);

  tx_state_e             state_q, ret_q, nxt_log, nxt_state;
  tx_kind_e              kind_q;
  logic                  write_q;
  logic [7:0]            addr_q;
  logic [1:0]            len_q, idx_q, idx_d, len_clamp;
  logic [8*MAX_DATA-1:0] payload_q;
  logic [CW-1:0]         cnt_q;
  logic [9:0]            sbtx_q;
  logic                  strobe_q, busy_q, done_q;

  logic [7:0]            cur_byte, nxt_byte, data_byte;
  logic                  sym_end, frame_end, has_data, stuffable;
  logic                  crc_init, crc_en;
  logic [15:0]           crc_q;

  always_comb begin
    len_clamp = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    cur_byte  = sbtx_q[8:1];
    sym_end   = (state_q != ST_IDLE) && (cnt_q == '0);
    has_data  = (len_q != 2'd0) && ((kind_q == KIND_CMD) ? write_q : !write_q);

    // Sequence ignoring stuffing; STUFF is spliced in below.
    nxt_log = ST_IDLE;
    case (state_q)
      ST_DLE_H:  nxt_log = (kind_q == KIND_LT) ? ST_LSE : ST_STX;
      ST_STX:    nxt_log = ST_ADDR;
      ST_ADDR:   nxt_log = ST_LEN;
      ST_LEN:    nxt_log = has_data ? ST_DATA : ST_CRC_LO;
      ST_DATA:   nxt_log = (({1'b0, idx_q} + 3'd1) < {1'b0, len_q}) ? ST_DATA : ST_CRC_LO;
      ST_CRC_LO: nxt_log = ST_CRC_HI;
      ST_CRC_HI: nxt_log = ST_DLE_T;
      ST_DLE_T:  nxt_log = ST_ETX;
      ST_STUFF:  nxt_log = ret_q;
      ST_LSE:    nxt_log = ST_CLSE;
      default:   nxt_log = ST_IDLE;
    endcase

    stuffable = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CRC_LO, ST_CRC_HI};
    nxt_state = (stuffable && (cur_byte == DLE)) ? ST_STUFF : nxt_log;

    // idx advances when a DATA symbol ends, so after STUFF it already
    // points at the following byte.
    idx_d = (sym_end && (state_q == ST_DATA)) ? idx_q + 2'd1 : idx_q;

    data_byte = 8'h00;
    for (int i = 0; i < MAX_DATA; i++)
      if (int'(idx_d) == i) data_byte = payload_q[8*i +: 8];

    nxt_byte = 8'hFF;
    case (nxt_state)
      ST_DLE_H, ST_STUFF, ST_DLE_T: nxt_byte = DLE;
      ST_STX:    nxt_byte = (kind_q == KIND_CMD) ? STX_CMD : STX_RSP;
      ST_ADDR:   nxt_byte = addr_q;
      ST_LEN:    nxt_byte = {write_q, 5'b0, len_q};
      ST_DATA:   nxt_byte = data_byte;
      ST_CRC_LO: nxt_byte = crc_q[7:0];
      ST_CRC_HI: nxt_byte = crc_q[15:8];
      ST_ETX:    nxt_byte = ETX;
      ST_LSE:    nxt_byte = LSE;
      ST_CLSE:   nxt_byte = CLSE;
      default:   nxt_byte = 8'hFF;
    endcase

    frame_end = sym_end && (nxt_state == ST_IDLE) && !tdisconnect;
    // CRC folds each covered byte as it goes onto the line; it is stable
    // for a full symbol before CRC_LO is loaded.
    crc_en    = sym_end && (nxt_state inside {ST_STX, ST_ADDR, ST_LEN, ST_DATA});
    crc_init  = tdisconnect || (state_q == ST_IDLE);
  end

  sb_crc16 u_crc (
    .sb_clk (sb_clk),
    .rst    (rst),
    .init   (crc_init),
    .en     (crc_en),
    .din    (nxt_byte),
    .crc    (crc_q)
  );

  always_ff @(posedge sb_clk) begin
    if (rst || tdisconnect) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      kind_q    <= KIND_CMD;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      payload_q <= '0;
      cnt_q     <= '0;
      sbtx_q    <= SBTX_IDLE;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      if (lt_fall_req || at_rsp_req || at_cmd_req) begin
        kind_q    <= lt_fall_req ? KIND_LT : (at_rsp_req ? KIND_RSP : KIND_CMD);
        write_q   <= req_write;
        addr_q    <= req_address;
        len_q     <= len_clamp;
        payload_q <= req_payload;
        idx_q     <= '0;
        state_q   <= ST_DLE_H;
        sbtx_q    <= {1'b1, DLE, 1'b0};
        strobe_q  <= 1'b1;
        busy_q    <= 1'b1;
        cnt_q     <= CNT_LOAD;
      end
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= idx_d;
      if (sym_end) begin
        if (frame_end) begin
          state_q <= ST_IDLE;
          sbtx_q  <= SBTX_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          state_q  <= nxt_state;
          sbtx_q   <= {1'b1, nxt_byte, 1'b0};
          strobe_q <= 1'b1;
          cnt_q    <= CNT_LOAD;
          if (nxt_state == ST_STUFF) ret_q <= nxt_log;
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef SB_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge sb_clk) begin
    if (rst)            frame_cnt_q <= '0;
    else if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign tx_frame_cnt = frame_cnt_q;
`endif

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign sbtx        = sbtx_q;
  assign sbtx_strobe = strobe_q;

endmodule
